// File: rtl/pwm_ramp_ctrl.sv
// Sequencing controller for pwm_gen: accepts a (ccr, arr, step) command and
// ramps ccr toward the target one step per PWM period, updating only at period ends.
module pwm_ramp_ctrl #(
  parameter int unsigned W         = 8,
  parameter int unsigned RESET_ARR = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_ccr,
  input  logic [W-1:0] cmd_arr,
  input  logic [W-1:0] cmd_step,
  input  logic         abort,
  output logic [W-1:0] ccr,
  output logic [W-1:0] arr,
  output logic         period_end,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] tgt_ccr;
  logic [W-1:0] tgt_arr;
  logic [W-1:0] stp;
  logic [W-1:0] ccr_nxt;
  logic         accept;
  logic         update;
  logic         finish;

  assign period_end = (cnt == arr);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == RAMP);
  assign accept     = cmd_valid && cmd_ready;

  // Snap to target when the remaining distance fits in one step, so the
  // unsigned add/subtract can never overshoot or wrap.
  always_comb begin
    ccr_nxt = tgt_ccr;
    if (ccr < tgt_ccr) begin
      if ((tgt_ccr - ccr) > stp) ccr_nxt = ccr + stp;
    end else if (ccr > tgt_ccr) begin
      if ((ccr - tgt_ccr) > stp) ccr_nxt = ccr - stp;
    end
  end

  always_comb begin
    state_nxt = state;
    update    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = RAMP;
      RAMP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (period_end) begin
          update = 1'b1;
          if (ccr_nxt == tgt_ccr) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ccr     <= '0;
      arr     <= W'(RESET_ARR);
      tgt_ccr <= '0;
      tgt_arr <= '0;
      stp     <= '0;
      done    <= 1'b0;
    end else begin
      cnt  <= period_end ? '0 : cnt + W'(1);
      done <= finish;
      if (accept) begin
        tgt_arr <= cmd_arr;
        tgt_ccr <= (cmd_ccr < cmd_arr) ? cmd_ccr : cmd_arr;
        stp     <= (cmd_step == '0) ? W'(1) : cmd_step;
      end
      if (update) begin
        arr <= tgt_arr;
        ccr <= ccr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps, clamp, abort, backpressure, async reset.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_ccr = '0;
  logic [7:0] cmd_arr = '0;
  logic [7:0] cmd_step = '0;
  logic       abort = 1'b0;
  logic [7:0] ccr;
  logic [7:0] arr;
  logic       period_end;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_seq [$];

  pwm_ramp_ctrl #(.W(8), .RESET_ARR(255)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ccr(cmd_ccr), .cmd_arr(cmd_arr), .cmd_step(cmd_step), .abort(abort),
    .ccr(ccr), .arr(arr), .period_end(period_end), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_pe(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (period_end) seen = 1'b1;
    end
    if (!seen) check_eq("pe_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("rst_ccr", int'(ccr), 0);
    check_eq("rst_arr", int'(arr), 255);
    check_eq("rst_ready", int'(cmd_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    reset = 1'b1;
  endtask

  task automatic issue_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    cmd_ccr = c;
    cmd_arr = a;
    cmd_step = s;
    cmd_valid = 1'b1;
    check_eq("ready_before_cmd", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_after_accept", int'(busy), 1);
  endtask

  // first_lat: negedges from command issue to first period_end (0 = unchecked);
  // sp: clocks between later period_ends (0 = unchecked).
  task automatic expect_ramp(input string name, input int exp_arr, input int first_lat, input int sp);
    int n;
    for (int i = 0; i < exp_seq.size(); i++) begin
      wait_pe(n);
      if (i == 0 && first_lat != 0) check_eq({name, "_first_lat"}, n + 1, first_lat);
      if (i > 0 && sp != 0) check_eq({name, "_spacing"}, n + 1, sp);
      @(negedge clk);
      check_eq({name, "_ccr"}, int'(ccr), int'(exp_seq[i]));
      check_eq({name, "_arr"}, int'(arr), exp_arr);
      check_eq({name, "_done"}, int'(done), (i == exp_seq.size() - 1) ? 1 : 0);
    end
    check_eq({name, "_ready_end"}, int'(cmd_ready), 1);
    check_eq({name, "_busy_end"}, int'(busy), 0);
    @(negedge clk);
    check_eq({name, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int n;
    int cnt_done;
    int cnt_chg;
    int early_ready;
    bit seen;

    // Up-ramp from reset: 0 -> 4 step 1, arr 5
    do_reset();
    issue_cmd(8'd4, 8'd5, 8'd1);
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4};
    expect_ramp("up4", 5, 255, 6);

    // Jump to 200/255, then down-ramp to 10 by 64
    issue_cmd(8'd200, 8'd255, 8'd255);
    exp_seq = '{8'd200};
    expect_ramp("to200", 255, 0, 0);
    issue_cmd(8'd10, 8'd255, 8'd64);
    exp_seq = '{8'd136, 8'd72, 8'd10};
    expect_ramp("down10", 255, 0, 256);

    // Clamp target to arr and step 0 treated as 1
    do_reset();
    issue_cmd(8'd9, 8'd5, 8'd0);
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    expect_ramp("clamp", 5, 255, 6);

    // Abort after two updates of 0 -> 100 step 10
    do_reset();
    issue_cmd(8'd100, 8'd255, 8'd10);
    wait_pe(n);
    @(negedge clk);
    check_eq("abort_upd1", int'(ccr), 10);
    wait_pe(n);
    @(negedge clk);
    check_eq("abort_upd2", int'(ccr), 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_ready", int'(cmd_ready), 1);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_ccr", int'(ccr), 20);
    check_eq("abort_arr", int'(arr), 255);
    cnt_done = 0;
    cnt_chg = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (ccr != 8'd20) cnt_chg++;
    end
    check_eq("abort_no_done", cnt_done, 0);
    check_eq("abort_frozen", cnt_chg, 0);

    // Abort coinciding with period_end: abort wins, no update
    issue_cmd(8'd50, 8'd255, 8'd10);
    wait_pe(n);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_pe_ccr", int'(ccr), 20);
    check_eq("abort_pe_busy", int'(busy), 0);
    check_eq("abort_pe_done", int'(done), 0);

    // Abort in IDLE with a command: command accepted (A: 20 -> 22 step 1)
    cmd_ccr = 8'd22; cmd_arr = 8'd255; cmd_step = 8'd1;
    abort = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("idle_abort_accept", int'(busy), 1);

    // Backpressure: hold command B through ramp A
    cmd_ccr = 8'd30; cmd_arr = 8'd40; cmd_step = 8'd4;
    seen = 1'b0;
    early_ready = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check_eq("bp_a_ccr", int'(ccr), 22);
        check_eq("bp_ready_in_done", int'(cmd_ready), 1);
      end else if (cmd_ready) begin
        early_ready++;
      end
    end
    check_eq("bp_a_done_seen", int'(seen), 1);
    check_eq("bp_ready_while_busy", early_ready, 0);
    @(negedge clk);
    check_eq("bp_b_accepted", int'(busy), 1);
    check_eq("bp_b_ccr_hold", int'(ccr), 22);
    cmd_valid = 1'b0;
    exp_seq = '{8'd26, 8'd30};
    expect_ramp("bp_b", 40, 0, 41);

    // Async reset mid-ramp, then resume
    issue_cmd(8'd100, 8'd255, 8'd1);
    wait_pe(n);
    @(negedge clk);
    check_eq("mid_ccr", int'(ccr), 31);
    check_eq("mid_arr", int'(arr), 255);
    #2 reset = 1'b0;
    #1;
    check_eq("async_ccr", int'(ccr), 0);
    check_eq("async_arr", int'(arr), 255);
    check_eq("async_ready", int'(cmd_ready), 1);
    check_eq("async_busy", int'(busy), 0);
    check_eq("async_pe", int'(period_end), 0);
    check_eq("async_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    issue_cmd(8'd2, 8'd3, 8'd1);
    exp_seq = '{8'd1, 8'd2};
    expect_ramp("resume", 3, 255, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
